// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard sources, branch and
// SRAM handshake in, freeze/flush controls and statistics out.
// Handshake: mem_req is held by the MEM stage for as long as its access is
// outstanding; the access completes in the cycle where mem_req and mem_ready
// are both 1. mem_ready without mem_req has no meaning and is ignored in RUN.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             use_src1;
  logic             two_src;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             forward_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             if_freeze;
  logic             id_freeze;
  logic             exe_freeze;
  logic             wb_bubble;
  logic             if_flush;
  logic             id_flush;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbg_state;

  // Pipeline side: drives hazard/branch/memory inputs, observes controls.
  modport master (
    output src1, src2, use_src1, two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, mem_ready,
    input  if_freeze, id_freeze, exe_freeze, wb_bubble, if_flush, id_flush,
           mem_timeout_err, stall_cnt, flush_cnt, dbg_state
  );

  // Controller side.
  modport slave (
    input  src1, src2, use_src1, two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, mem_ready,
    output if_freeze, id_freeze, exe_freeze, wb_bubble, if_flush, id_flush,
           mem_timeout_err, stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Priority each cycle: memory stall > branch flush > data hazard.
// Controls are Mealy outputs of the state and the current-cycle inputs;
// the error flag, counters and state are registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic exe_m1, exe_m2, mem_m1, mem_m2;
  logic hazard;
  logic mem_stall, br_flush, hz_stall;
  logic if_freeze_w;

  // Data hazard: the ID instruction reads a register still owed by EXE/MEM.
  always_comb begin
    exe_m1 = hz.use_src1 && (hz.src1 == hz.exe_dest);
    exe_m2 = hz.two_src  && (hz.src2 == hz.exe_dest);
    mem_m1 = hz.use_src1 && (hz.src1 == hz.mem_dest);
    mem_m2 = hz.two_src  && (hz.src2 == hz.mem_dest);
    if (hz.forward_en) begin
      // Only a load in EXE cannot be forwarded in time.
      hazard = hz.exe_mem_read && (exe_m1 || exe_m2);
    end else begin
      hazard = (hz.exe_wb_en && (exe_m1 || exe_m2)) ||
               (hz.mem_wb_en && (mem_m1 || mem_m2));
    end
  end

  // FSM next state and per-cycle control decision.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    mem_stall  = 1'b0;
    br_flush   = 1'b0;
    hz_stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          mem_stall  = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (hz.branch_taken) begin
          br_flush = 1'b1;
        end else if (hazard) begin
          hz_stall = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Branch and hazard wait: EXE is frozen so they persist.
        mem_stall = 1'b1;
        if (hz.mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        // Terminal until reset.
        mem_stall = 1'b1;
        err_d     = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Pipeline controls, all held low while reset is asserted.
  always_comb begin
    if_freeze_w   = rst && (mem_stall || hz_stall);
    hz.if_freeze  = if_freeze_w;
    hz.id_freeze  = rst && mem_stall;
    hz.exe_freeze = rst && mem_stall;
    hz.wb_bubble  = rst && mem_stall;
    hz.if_flush   = rst && br_flush;
    hz.id_flush   = rst && (br_flush || hz_stall);
  end

  // Saturating statistics counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (if_freeze_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (rst && br_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter, sticky error and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    hz.mem_timeout_err = err_q;
    hz.stall_cnt       = stall_cnt_q;
    hz.flush_cnt       = flush_cnt_q;
    hz.dbg_state       = state_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the pipeline rules.
module tb_pipeline_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MT   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // Packed control vector order: {if_freeze,id_freeze,exe_freeze,wb_bubble,if_flush,id_flush}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_MEM   = 6'b111100;
  localparam logic [5:0] O_BR    = 6'b000011;
  localparam logic [5:0] O_HAZ   = 6'b100001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

  pipeline_hazard_ctrl #(
    .CNT_W       (CW),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int         m_age;     // cycles the current request has gone unserved (0 = none)
  bit         m_err;
  int         m_stall;
  int         m_flush;

  logic [5:0]    obs_o, exp_o;
  logic          obs_err, exp_err;
  logic [CW-1:0] obs_stall, exp_stall, obs_flush, exp_flush;
  logic [5:0]    exp_q[$];

  function automatic bit model_hazard();
    logic [15:0] rd;
    logic [15:0] owed;
    rd   = '0;
    owed = '0;
    if (hz_if.use_src1) rd[hz_if.src1] = 1'b1;
    if (hz_if.two_src)  rd[hz_if.src2] = 1'b1;
    if (hz_if.forward_en) begin
      if (hz_if.exe_mem_read) owed[hz_if.exe_dest] = 1'b1;
    end else begin
      if (hz_if.exe_wb_en) owed[hz_if.exe_dest] = 1'b1;
      if (hz_if.mem_wb_en) owed[hz_if.mem_dest] = 1'b1;
    end
    return |(rd & owed);
  endfunction

  function automatic logic [5:0] model_out();
    bit mem_stall;
    if (!rst) return O_NONE;
    mem_stall = m_err || (m_age > 0) || (hz_if.mem_req && !hz_if.mem_ready);
    if (mem_stall)          return O_MEM;
    if (hz_if.branch_taken) return O_BR;
    if (model_hazard())     return O_HAZ;
    return O_NONE;
  endfunction

  function automatic void model_reset();
    m_age   = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic void model_update(logic [5:0] o);
    if (!rst) begin
      model_reset();
      return;
    end
    if (o[5] && m_stall < CMAX) m_stall++;
    if (o == O_BR && m_flush < CMAX) m_flush++;
    if (m_err) return;
    if (m_age > 0) begin
      if (hz_if.mem_ready) m_age = 0;
      else begin
        m_age++;
        if (m_age == 1 + MT) m_err = 1'b1;
      end
    end else if (hz_if.mem_req && !hz_if.mem_ready) begin
      m_age = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    hz_if.src1 = '0; hz_if.src2 = '0; hz_if.use_src1 = 1'b0; hz_if.two_src = 1'b0;
    hz_if.exe_dest = '0; hz_if.exe_wb_en = 1'b0; hz_if.exe_mem_read = 1'b0;
    hz_if.mem_dest = '0; hz_if.mem_wb_en = 1'b0; hz_if.forward_en = 1'b0;
    hz_if.branch_taken = 1'b0; hz_if.mem_req = 1'b0; hz_if.mem_ready = 1'b0;
  endtask

  task automatic drive_mem(input logic req, input logic rdy);
    hz_if.mem_req   = req;
    hz_if.mem_ready = rdy;
  endtask

  task automatic drive_load_use();
    hz_if.forward_en = 1'b1; hz_if.exe_mem_read = 1'b1; hz_if.exe_wb_en = 1'b1;
    hz_if.exe_dest = 4'd3; hz_if.src1 = 4'd3; hz_if.use_src1 = 1'b1;
  endtask

  // One clock: sample at negedge, then the model follows the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_o     = {hz_if.if_freeze, hz_if.id_freeze, hz_if.exe_freeze,
                 hz_if.wb_bubble, hz_if.if_flush, hz_if.id_flush};
    obs_err   = hz_if.mem_timeout_err;
    obs_stall = hz_if.stall_cnt;
    obs_flush = hz_if.flush_cnt;
    exp_o     = model_out();
    exp_err   = m_err;
    exp_stall = CW'(m_stall);
    exp_flush = CW'(m_flush);
    @(posedge clk);
    model_update(exp_o);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive_idle();
    drive_mem(1'b1, 1'b0);
    hz_if.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_o !== O_NONE || obs_stall !== '0 || obs_flush !== '0 || obs_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: ctl=%b stall=%0d flush=%0d err=%b, want ctl=000000 counters 0 err 0",
                 obs_o, obs_stall, obs_flush, obs_err);
      end
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (obs_o !== O_MEM || exp_o !== O_MEM) begin
      failures++;
      $display("FAIL reset_release: ctl=%b want %b", obs_o, O_MEM);
    end
    drive_mem(1'b1, 1'b1);
    cycle();
    checks++;
    if (obs_o !== O_MEM) begin
      failures++;
      $display("FAIL reset_release_ready: ctl=%b want %b", obs_o, O_MEM);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_load_use();
    cycle();
    checks++;
    if (obs_o !== O_HAZ || exp_o !== O_HAZ) begin
      failures++;
      $display("FAIL load_use: ctl=%b want %b", obs_o, O_HAZ);
    end
    drive_idle();
    cycle();
    checks++;
    if (obs_o !== O_NONE || obs_stall !== CW'(1) || exp_stall !== CW'(1)) begin
      failures++;
      $display("FAIL load_use_after: ctl=%b stall=%0d want ctl=000000 stall=1", obs_o, obs_stall);
    end
  endtask

  task automatic test_no_forward();
    apply_reset();
    hz_if.forward_en = 1'b0; hz_if.mem_wb_en = 1'b1; hz_if.mem_dest = 4'd5;
    hz_if.two_src = 1'b1; hz_if.src2 = 4'd5;
    cycle();
    checks++;
    if (obs_o !== O_HAZ || exp_o !== O_HAZ) begin
      failures++;
      $display("FAIL no_fwd_mem_match: ctl=%b want %b", obs_o, O_HAZ);
    end
    hz_if.forward_en = 1'b1;
    cycle();
    checks++;
    if (obs_o !== O_NONE || exp_o !== O_NONE) begin
      failures++;
      $display("FAIL fwd_mem_match: ctl=%b want %b", obs_o, O_NONE);
    end
    drive_idle();
  endtask

  task automatic test_branch_vs_hazard();
    apply_reset();
    drive_load_use();
    hz_if.branch_taken = 1'b1;
    cycle();
    checks++;
    if (obs_o !== O_BR || exp_o !== O_BR) begin
      failures++;
      $display("FAIL branch_prio: ctl=%b want %b", obs_o, O_BR);
    end
    drive_idle();
    cycle();
    checks++;
    if (obs_flush !== CW'(1) || obs_stall !== '0) begin
      failures++;
      $display("FAIL branch_counts: flush=%0d stall=%0d want flush=1 stall=0", obs_flush, obs_stall);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    drive_mem(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) hz_if.mem_ready = 1'b1;
      cycle();
      checks++;
      if (obs_o !== O_MEM || exp_o !== O_MEM) begin
        failures++;
        $display("FAIL mem_wait_cyc%0d: ctl=%b want %b", i, obs_o, O_MEM);
      end
    end
    drive_mem(1'b0, 1'b0);
    cycle();
    checks++;
    if (obs_o !== O_NONE || obs_stall !== CW'(4)) begin
      failures++;
      $display("FAIL mem_wait_done: ctl=%b stall=%0d want ctl=000000 stall=4", obs_o, obs_stall);
    end
    // Ready together with the request: no freeze.
    drive_mem(1'b1, 1'b1);
    cycle();
    checks++;
    if (obs_o !== O_NONE || obs_stall !== CW'(4)) begin
      failures++;
      $display("FAIL mem_ready_n1: ctl=%b stall=%0d want ctl=000000 stall=4", obs_o, obs_stall);
    end
    // Branch during a memory wait is held off, then acted on.
    drive_mem(1'b1, 1'b0);
    hz_if.branch_taken = 1'b1;
    cycle();
    hz_if.mem_ready = 1'b1;
    cycle();
    checks++;
    if (obs_o !== O_MEM) begin
      failures++;
      $display("FAIL branch_in_wait: ctl=%b want %b", obs_o, O_MEM);
    end
    drive_mem(1'b0, 1'b0);
    cycle();
    checks++;
    if (obs_o !== O_BR || obs_flush !== '0) begin
      failures++;
      $display("FAIL branch_after_wait: ctl=%b flush=%0d want %b flush=0", obs_o, obs_flush, O_BR);
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    apply_reset();
    drive_mem(1'b1, 1'b0);
    for (int i = 1; i <= 1 + MT; i++) begin
      cycle();
      checks++;
      if (obs_o !== O_MEM || obs_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_pre%0d: ctl=%b err=%b want %b err=0", i, obs_o, obs_err, O_MEM);
      end
    end
    cycle();
    checks++;
    if (obs_err !== 1'b1 || exp_err !== 1'b1 || obs_o !== O_MEM) begin
      failures++;
      $display("FAIL timeout_err: err=%b ctl=%b want err=1 ctl=%b", obs_err, obs_o, O_MEM);
    end
    drive_mem(1'b0, 1'b1);
    hz_if.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_o !== O_MEM || obs_err !== 1'b1) begin
        failures++;
        $display("FAIL timeout_sticky: ctl=%b err=%b want %b err=1", obs_o, obs_err, O_MEM);
      end
    end
    apply_reset();
    cycle();
    checks++;
    if (obs_o !== O_NONE || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_cleared: ctl=%b err=%b want 000000 err=0", obs_o, obs_err);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive_mem(1'b1, 1'b0);
    for (int i = 0; i < CMAX + 5; i++) cycle();
    cycle();
    checks++;
    if (obs_stall !== CW'(CMAX) || exp_stall !== CW'(CMAX)) begin
      failures++;
      $display("FAIL stall_saturate: stall=%0d want %0d", obs_stall, CMAX);
    end
    apply_reset();
    hz_if.branch_taken = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) cycle();
    cycle();
    checks++;
    if (obs_flush !== CW'(CMAX) || obs_stall !== '0) begin
      failures++;
      $display("FAIL flush_saturate: flush=%0d stall=%0d want flush=%0d stall=0", obs_flush, obs_stall, CMAX);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [5:0] want;
    int         bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 60 == 0) apply_reset();
      hz_if.src1         = 4'($urandom_range(0, 3));
      hz_if.src2         = 4'($urandom_range(0, 3));
      hz_if.use_src1     = 1'($urandom_range(0, 1));
      hz_if.two_src      = 1'($urandom_range(0, 1));
      hz_if.exe_dest     = 4'($urandom_range(0, 3));
      hz_if.exe_wb_en    = 1'($urandom_range(0, 1));
      hz_if.exe_mem_read = 1'($urandom_range(0, 1));
      hz_if.mem_dest     = 4'($urandom_range(0, 3));
      hz_if.mem_wb_en    = 1'($urandom_range(0, 1));
      hz_if.forward_en   = 1'($urandom_range(0, 1));
      hz_if.branch_taken = ($urandom_range(0, 7) == 0);
      hz_if.mem_req      = ($urandom_range(0, 3) == 0);
      hz_if.mem_ready    = ($urandom_range(0, 3) != 0);
      cycle();
      exp_q.push_back(exp_o);
      want = exp_q.pop_front();
      checks++;
      if (obs_o !== want || obs_stall !== exp_stall || obs_flush !== exp_flush || obs_err !== exp_err) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cyc%0d: ctl=%b stall=%0d flush=%0d err=%b want ctl=%b stall=%0d flush=%0d err=%b",
                   n, obs_o, obs_stall, obs_flush, obs_err, want, exp_stall, exp_flush, exp_err);
      end
    end
    drive_idle();
  endtask

  // ---------------- sequencer and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    model_reset();
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch_vs_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage ARM-subset pipeline. Every cycle it computes the freeze and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Inputs are the ID-stage source operands, the EXE/MEM destinations, the EXE-stage branch decision and the data-memory (SRAM) handshake. A small FSM tracks multi-cycle memory waits, flags a memory timeout, and keeps saturating stall/flush statistics counters.

## Interface
- CNT_W, 16, width of the stall and flush statistics counters
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before an error is declared (≥2)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- src1, src2  in  4  ID-stage source register numbers
- use_src1  in  1  src1 is read by the ID instruction
- two_src  in  1  src2 is read by the ID instruction
- exe_dest  in  4  destination register of the EXE-stage instruction
- exe_wb_en, exe_mem_read  in  1  EXE-stage write-back enable and load flag
- mem_dest  in  4  destination register of the MEM-stage instruction
- mem_wb_en  in  1  MEM-stage write-back enable
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_req  in  1  MEM-stage instruction accesses SRAM (read or write)
- mem_ready  in  1  SRAM access completes this cycle
- if_freeze  out  1  hold PC and IF/ID register
- id_freeze  out  1  hold ID/EX register
- exe_freeze  out  1  hold EX/MEM register
- wb_bubble  out  1  load zero-control bubble into MEM/WB
- if_flush  out  1  clear IF/ID register
- id_flush  out  1  clear ID/EX register
- mem_timeout_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  cycles with if_freeze=1, saturating
- flush_cnt  out  CNT_W  branch-flush cycles, saturating

## Operation
- Data hazard (combinational):
  - Operand match: m1 = use_src1 & (src1==D); m2 = two_src & (src2==D).
  - forward_en=0: hazard = (m1|m2) for D=exe_dest with exe_wb_en=1, or for D=mem_dest with mem_wb_en=1.
  - forward_en=1: hazard = exe_mem_read & (m1|m2) for D=exe_dest only.
- FSM states are RUN, MEM_WAIT and ERR.
- RUN:
  - mem_req & ~mem_ready:
    - Assert the memory stall this cycle: if_freeze=id_freeze=exe_freeze=wb_bubble=1, flushes 0.
    - Next state MEM_WAIT, wait_cnt←0.
  - Else if branch_taken: if_flush=id_flush=1, all freezes 0, flush_cnt+1.
  - Else if hazard: if_freeze=1, id_flush=1 (bubble), id_freeze=exe_freeze=0.
  - Else all outputs 0.
- MEM_WAIT:
  - Assert the memory stall; branch and hazard are ignored.
  - mem_ready=1: stall still asserted this cycle, next state RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: next state ERR.
  - Else wait_cnt+1.
- ERR: memory stall held permanently, mem_timeout_err=1; exit only by reset.
- Priority is memory stall > branch flush > data hazard.
- A branch arriving during a memory stall is not lost: EXE is frozen, so branch_taken persists and is acted on in the first RUN cycle.
- Counters:
  - stall_cnt increments every cycle if_freeze=1; flush_cnt increments every branch-flush cycle.
  - Both stop at 2^CNT_W-1 with no wrap.
- Reset (rst=0):
  - Asynchronous, takes effect immediately: state RUN, wait_cnt=0, counters 0, mem_timeout_err=0.
  - All freeze/flush/bubble outputs forced 0 while rst=0.
  - Reset mid-MEM_WAIT or in ERR returns to RUN.

## Timing
- Freeze/flush outputs are combinational (Mealy) from state and current-cycle inputs; zero-cycle latency to the pipeline registers sampling at the next edge.
- Load-use: exactly one bubble per dependent instruction with forwarding on; hazard clears once the producer leaves the checked stage.
- Memory access with ready at cycle N of the request (N≥1):
  - Freezes are asserted for N cycles. With N=1 (ready with the request) there is no freeze.
  - Error is raised after 1+MEM_TIMEOUT cycles of request without ready.
- mem_timeout_err, stall_cnt, flush_cnt and state are registered; the counters update on the edge following the qualifying cycle.

## Test plan
- Reset: hold rst=0 with mem_req=1, mem_ready=0, branch_taken=1 -> all outputs 0, counters 0; release -> memory stall asserted.
- Load-use: forward_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=3, src1=3, use_src1=1 for one cycle -> if_freeze=1, id_flush=1 one cycle; stall_cnt=1.
- No forwarding: forward_en=0, mem_wb_en=1, mem_dest=5, two_src=1, src2=5 -> hazard stall; same case with forward_en=1 -> no stall.
- Branch vs hazard: branch_taken=1 together with a load-use match -> if_flush=id_flush=1, if_freeze=0; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready asserted on the 4th cycle -> freezes and wb_bubble high for 4 cycles, then back in RUN; stall_cnt=4.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after 5 cycles, stall persists; a later mem_ready=1 is ignored until rst.
